req_fifo_frontend: RTL and testbench

Upstream requester stage for the two-port arbiter. Buffers writes from two independent sources in per-port FIFOs, drives `req_0`/`req_1` whenever the corresponding FIFO holds data, and pops one word per cycle on the port the arbiter grants. Popped words appear on a single registered output bus tagged with their source port.

---
 rtl/req_fe_pkg.sv | 13 +
 rtl/req_fifo.sv | 67 ++++++
 rtl/req_fifo_frontend.sv | 113 +++++++++++
 tb/tb_req_fifo_frontend.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/req_fe_pkg.sv
// req_fe_pkg: shared defaults and helpers for the requester front end.
//   DEF_DATA_W / DEF_DEPTH : default word width and per-port FIFO depth.
//   clog2()                : pointer-width helper.
package req_fe_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    function automatic int clog2(input int v);
        return $clog2(v);
    endfunction

endpackage

// File: rtl/req_fifo.sv
// req_fifo: single-port circular FIFO, one per requester port.
//   i_clock, i_reset  : clock, synchronous active-high reset
//   i_wr_en, i_wr_data: write strobe/data (dropped while full)
//   i_rd_en           : pop head (ignored while empty)
//   o_rd_data         : current head word (valid when !o_empty)
//   o_full, o_empty   : occupancy flags from registered count
//   o_count           : occupancy 0..DEPTH
module req_fifo
    import req_fe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Full check uses the registered count, so a pop in the same cycle
    // does not make room for a write.
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge i_clock) begin
        if (w_wr && !i_reset)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/req_fifo_frontend.sv
// req_fifo_frontend: two-port requester stage in front of the arbiter.
// Buffers each port in a req_fifo, requests while non-empty, pops on an
// exclusive grant and registers the popped word with its source port.
//   i_clock, i_reset              : clock, synchronous active-high reset
//   i_wr_en_N, i_wr_data_N        : port N write strobe/data
//   o_full_N, o_count_N           : port N FIFO status
//   o_req_N / i_gnt_N             : request to / grant from arbiter
//   o_out_valid/o_out_data/o_out_src : registered popped word and source
//   o_gnt_err                     : sticky both-grants error flag
// Build option: define GNT_ERR_EN to implement o_gnt_err; otherwise it is 0.
module req_fifo_frontend
    import req_fe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int CNT_W = clog2(DEPTH) + 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wr_en_0,
    input  logic [DATA_W-1:0] i_wr_data_0,
    output logic              o_full_0,
    output logic [CNT_W-1:0]  o_count_0,
    input  logic              i_wr_en_1,
    input  logic [DATA_W-1:0] i_wr_data_1,
    output logic              o_full_1,
    output logic [CNT_W-1:0]  o_count_1,
    output logic              o_req_0,
    output logic              o_req_1,
    input  logic              i_gnt_0,
    input  logic              i_gnt_1,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_src,
    output logic              o_gnt_err
);

    logic [DATA_W-1:0] w_head_0, w_head_1;
    logic              w_empty_0, w_empty_1;
    logic              w_pop_0, w_pop_1;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_src;

    // Grants on an empty FIFO (lingering after the last pop) are ignored.
    assign w_pop_0 = i_gnt_0 && !i_gnt_1 && !w_empty_0;
    assign w_pop_1 = i_gnt_1 && !i_gnt_0 && !w_empty_1;

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_0 (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en_0),
        .i_wr_data (i_wr_data_0),
        .i_rd_en   (w_pop_0),
        .o_rd_data (w_head_0),
        .o_full    (o_full_0),
        .o_empty   (w_empty_0),
        .o_count   (o_count_0)
    );

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en_1),
        .i_wr_data (i_wr_data_1),
        .i_rd_en   (w_pop_1),
        .o_rd_data (w_head_1),
        .o_full    (o_full_1),
        .o_empty   (w_empty_1),
        .o_count   (o_count_1)
    );

    // Requests come from registered occupancy only.
    assign o_req_0 = !w_empty_0;
    assign o_req_1 = !w_empty_1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
        end else begin
            r_out_valid <= w_pop_0 || w_pop_1;
            if (w_pop_0) begin
                r_out_data <= w_head_0;
                r_out_src  <= 1'b0;
            end else if (w_pop_1) begin
                r_out_data <= w_head_1;
                r_out_src  <= 1'b1;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;

`ifdef GNT_ERR_EN
    logic r_gnt_err;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_gnt_err <= 1'b0;
        else if (i_gnt_0 && i_gnt_1)
            r_gnt_err <= 1'b1;
    end

    assign o_gnt_err = r_gnt_err;
`else
    assign o_gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_req_fifo_frontend.sv
module tb_req_fifo_frontend;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef GNT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1, g0, g1;
    logic [DATA_W-1:0] d0, d1;
    logic              full_0, full_1, req_0, req_1, ov, os, gerr;
    logic [CNT_W-1:0]  cnt_0, cnt_1;
    logic [DATA_W-1:0] od;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    req_fifo_frontend #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_wr_en_0   (we0),
        .i_wr_data_0 (d0),
        .o_full_0    (full_0),
        .o_count_0   (cnt_0),
        .i_wr_en_1   (we1),
        .i_wr_data_1 (d1),
        .o_full_1    (full_1),
        .o_count_1   (cnt_1),
        .o_req_0     (req_0),
        .o_req_1     (req_1),
        .i_gnt_0     (g0),
        .i_gnt_1     (g1),
        .o_out_valid (ov),
        .o_out_data  (od),
        .o_out_src   (os),
        .o_gnt_err   (gerr)
    );

    typedef struct {
        bit       rst, we0;
        bit [7:0] d0;
        bit       we1;
        bit [7:0] d1;
        bit       g0, g1;
        bit       req0, req1;
        int       c0, c1;
        bit       f0, f1, ov;
        bit [7:0] od;
        bit       os, err;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input int step, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step %0d: got 0x%0h want 0x%0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w0, input bit [7:0] x0,
                         input bit w1, input bit [7:0] x1, input bit a0, input bit a1);
        @(negedge clk);
        rst = r; we0 = w0; d0 = x0; we1 = w1; d1 = x1; g0 = a0; g1 = a1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        bit [7:0] exp_w [3];

        rst = 1'b1; we0 = 0; we1 = 0; d0 = 0; d1 = 0; g0 = 0; g1 = 0;

        //            rst we0 d0   we1 d1   g0 g1  rq0 rq1 c0 c1 f0 f1 ov od   os err
        tv.push_back('{1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0});
        tv.push_back('{0, 1, 8'hA1, 0, 8'h00, 0, 0,  1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 1, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 0, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 8'h10, 0, 0,  0, 1, 0, 1, 0, 0, 0, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 8'h11, 0, 0,  0, 1, 0, 2, 0, 0, 0, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 8'h12, 0, 0,  0, 1, 0, 3, 0, 0, 0, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 8'h13, 0, 0,  0, 1, 0, 4, 0, 1, 0, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 8'h14, 0, 0,  0, 1, 0, 4, 0, 1, 0, 8'hA1, 0, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 0, 3, 0, 0, 1, 8'h10, 1, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 0, 2, 0, 0, 1, 8'h11, 1, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 0, 1, 0, 0, 1, 8'h12, 1, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 0, 0, 0, 1, 8'h13, 1, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 0, 0, 0, 0, 8'h13, 1, 0});
        tv.push_back('{0, 1, 8'h20, 0, 8'h00, 0, 0,  1, 0, 1, 0, 0, 0, 0, 8'h13, 1, 0});
        tv.push_back('{0, 1, 8'h21, 0, 8'h00, 0, 0,  1, 0, 2, 0, 0, 0, 0, 8'h13, 1, 0});
        tv.push_back('{0, 1, 8'h22, 0, 8'h00, 0, 0,  1, 0, 3, 0, 0, 0, 0, 8'h13, 1, 0});
        tv.push_back('{0, 1, 8'h23, 0, 8'h00, 0, 0,  1, 0, 4, 0, 1, 0, 0, 8'h13, 1, 0});
        // write while full is dropped even with a pop in the same cycle
        tv.push_back('{0, 1, 8'h24, 0, 8'h00, 1, 0,  1, 0, 3, 0, 0, 0, 1, 8'h20, 0, 0});
        // write + pop on a non-full FIFO: count unchanged
        tv.push_back('{0, 1, 8'h25, 0, 8'h00, 1, 0,  1, 0, 3, 0, 0, 0, 1, 8'h21, 0, 0});
        // write to empty port 1 with its grant high: no pop
        tv.push_back('{0, 0, 8'h00, 1, 8'h30, 0, 1,  1, 1, 3, 1, 0, 0, 0, 8'h21, 0, 0});
        tv.push_back('{0, 0, 8'h00, 1, 8'h31, 0, 0,  1, 1, 3, 2, 0, 0, 0, 8'h21, 0, 0});
        // both grants: no pop, error flag when built in
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 3, 2, 0, 0, 0, 8'h21, 0, 1});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0,  1, 1, 2, 2, 0, 0, 1, 8'h22, 0, 1});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 2, 1, 0, 0, 1, 8'h30, 1, 1});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0,  1, 1, 1, 1, 0, 0, 1, 8'h23, 0, 1});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1,  1, 0, 1, 0, 0, 0, 1, 8'h31, 1, 1});
        tv.push_back('{0, 1, 8'h40, 1, 8'h41, 0, 0,  1, 1, 2, 1, 0, 0, 0, 8'h31, 1, 1});
        // reset with 3 words queued; write/grant in the reset cycle ignored
        tv.push_back('{1, 1, 8'h50, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0});
        tv.push_back('{0, 1, 8'h5A, 0, 8'h00, 0, 0,  1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0});
        tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0, 0, 1, 8'h5A, 0, 0});

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].we0, tv[i].d0, tv[i].we1, tv[i].d1, tv[i].g0, tv[i].g1);
            check("req_0",     i, int'(req_0),  int'(tv[i].req0));
            check("req_1",     i, int'(req_1),  int'(tv[i].req1));
            check("count_0",   i, int'(cnt_0),  tv[i].c0);
            check("count_1",   i, int'(cnt_1),  tv[i].c1);
            check("full_0",    i, int'(full_0), int'(tv[i].f0));
            check("full_1",    i, int'(full_1), int'(tv[i].f1));
            check("out_valid", i, int'(ov),     int'(tv[i].ov));
            check("out_data",  i, int'(od),     int'(tv[i].od));
            check("out_src",   i, int'(os),     int'(tv[i].os));
            check("gnt_err",   i, int'(gerr),   int'(tv[i].err && ERR_EN));
        end

        // Sustained grant drains in write order; bounded wait per word.
        exp_w[0] = 8'h61; exp_w[1] = 8'h62; exp_w[2] = 8'h63;
        for (int k = 0; k < 3; k++) drive(0, 1, exp_w[k], 0, 8'h00, 0, 0);
        check("seq_count", 100, int'(cnt_0), 3);
        got = 0;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            drive(0, 0, 8'h00, 0, 8'h00, 1, 0);
            if (ov) begin
                check("seq_data", 100 + got, int'(od), int'(exp_w[got]));
                check("seq_src",  100 + got, int'(os), 0);
                got++;
            end
        end
        check("seq_words", 110, got, 3);
        drive(0, 0, 8'h00, 0, 8'h00, 1, 0);
        check("seq_no_extra", 111, int'(ov), 0);
        check("seq_req_low",  112, int'(req_0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
